// File: rtl/bomb_timer_if.sv
// Control/status bundle between the game controller (master) and the countdown timer (slave).
interface bomb_timer_if #(
   parameter int TIME_W = 8
);
   logic              start;
   logic              stop;
   logic              pause;
   logic              penalty;
   logic [TIME_W-1:0] cur_time;
   logic [1:0]        s_time;
   logic              tick;
   logic              warn;

   modport master (
      output start, stop, pause, penalty,
      input  cur_time, s_time, tick, warn
   );

   modport slave (
      input  start, stop, pause, penalty,
      output cur_time, s_time, tick, warn
   );
endinterface

// File: rtl/bomb_timer_ctrl.sv
// Game countdown: loads START_SECS on start, decrements once per TICK_DIV cycles, flags expiry/low time.
// Latency: all outputs registered, one cycle after the controlling input; optional penalty via TIMER_PENALTY_EN.
// Backpressure: none; pause is a level that freezes prescaler and count.
module bomb_timer_ctrl #(
   parameter int TICK_DIV     = 50_000_000,
   parameter int TIME_W       = 8,
   parameter int START_SECS   = 60,
   parameter int WARN_SECS    = 10,
   parameter int PENALTY_SECS = 5
) (
   input  logic        clk,
   input  logic        rst,
   bomb_timer_if.slave bus
);

   localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
   localparam logic [TIME_W-1:0] START_VAL = TIME_W'(START_SECS);
   localparam logic [TIME_W-1:0] WARN_VAL  = TIME_W'(WARN_SECS);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_RUN     = 2'b01,
      ST_EXPIRED = 2'b10,
      ST_PAUSE   = 2'b11
   } state_t;

   generate
      if (TICK_DIV < 2) begin : g_bad_div
         $error("bomb_timer_ctrl: TICK_DIV must be >= 2");
      end
      if (START_SECS < 1 || START_SECS >= (1 << TIME_W)) begin : g_bad_start
         $error("bomb_timer_ctrl: START_SECS must fit in TIME_W bits");
      end
      if (PENALTY_SECS < 0 || PENALTY_SECS >= (1 << TIME_W)) begin : g_bad_pen
         $error("bomb_timer_ctrl: PENALTY_SECS out of range");
      end
   endgenerate

   state_t            state_q, state_d;
   logic [TIME_W-1:0] time_q, time_d;
   logic [PRE_W-1:0]  pre_q, pre_d;
   logic              tick_q, tick_d;
   logic              warn_q, warn_d;
   logic [TIME_W:0]   sub_amt;
   logic              pre_wrap;

   // One bit wider than cur_time so PENALTY_SECS+1 cannot overflow the subtrahend.
   function automatic logic [TIME_W-1:0] sat_sub(input logic [TIME_W-1:0] a,
                                                 input logic [TIME_W:0]   b);
      if ({1'b0, a} <= b) return '0;
      return a - b[TIME_W-1:0];
   endfunction

`ifdef TIMER_PENALTY_EN
   localparam logic [TIME_W:0] PEN_AMT = (TIME_W+1)'(PENALTY_SECS);
   logic pen_hit;
   assign pen_hit = bus.penalty;
`else
   logic unused_penalty;
   assign unused_penalty = bus.penalty;
`endif

   assign pre_wrap = (pre_q == PRE_LAST);

   always_comb begin
      state_d = state_q;
      time_d  = time_q;
      pre_d   = pre_q;
      tick_d  = 1'b0;
      sub_amt = '0;

      if (bus.stop) begin
         state_d = ST_IDLE;
      end else if (bus.start) begin
         state_d = ST_RUN;
         time_d  = START_VAL;
         pre_d   = '0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (bus.pause) begin
                  state_d = ST_PAUSE;
               end else if (pre_wrap) begin
                  pre_d   = '0;
                  tick_d  = 1'b1;
                  sub_amt = (TIME_W+1)'(1);
               end else begin
                  pre_d = pre_q + PRE_W'(1);
               end
            end
            ST_PAUSE: begin
               if (!bus.pause) state_d = ST_RUN;
            end
            default: ;
         endcase

`ifdef TIMER_PENALTY_EN
         if (pen_hit && (state_q == ST_RUN || state_q == ST_PAUSE))
            sub_amt = sub_amt + PEN_AMT;
`endif

         // Penalty and tick share one saturating update so expiry lands with the final value.
         if (sub_amt != '0) begin
            time_d = sat_sub(time_q, sub_amt);
            if (time_d == '0) state_d = ST_EXPIRED;
         end
      end

      warn_d = (state_d == ST_RUN || state_d == ST_PAUSE) &&
               (time_d != '0) && (time_d <= WARN_VAL);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         time_q  <= START_VAL;
         pre_q   <= '0;
         tick_q  <= 1'b0;
         warn_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         time_q  <= time_d;
         pre_q   <= pre_d;
         tick_q  <= tick_d;
         warn_q  <= warn_d;
      end
   end

   assign bus.cur_time = time_q;
   assign bus.s_time   = state_q;
   assign bus.tick     = tick_q;
   assign bus.warn     = warn_q;

endmodule

// File: tb/tb_bomb_timer_ctrl.sv
// Randomised and directed bench for bomb_timer_ctrl against a cycle-level behavioural model.
module tb_bomb_timer_ctrl;
   localparam int TICK_DIV     = 4;
   localparam int TIME_W       = 8;
   localparam int START_SECS   = 3;
   localparam int WARN_SECS    = 1;
   localparam int PENALTY_SECS = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bomb_timer_if #(.TIME_W(TIME_W)) bus ();

   bomb_timer_ctrl #(
      .TICK_DIV    (TICK_DIV),
      .TIME_W      (TIME_W),
      .START_SECS  (START_SECS),
      .WARN_SECS   (WARN_SECS),
      .PENALTY_SECS(PENALTY_SECS)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int checks   = 0;
   int failures = 0;

   // Model: state as its s_time code, seconds left, run cycles elapsed since last decrement.
   int   m_st, m_time, m_el;
   logic m_tick, m_warn;

   function automatic logic [11:0] obs();
      return {bus.cur_time, bus.s_time, bus.tick, bus.warn};
   endfunction

   function automatic logic [11:0] expv();
      logic [31:0] t, s;
      t = m_time;
      s = m_st;
      return {t[7:0], s[1:0], m_tick, m_warn};
   endfunction

   task automatic model_edge();
      int sub;
      sub    = 0;
      m_tick = 1'b0;
      if (!rst) begin
         m_st = 0; m_time = START_SECS; m_el = 0;
      end else if (bus.stop) begin
         m_st = 0;
      end else if (bus.start) begin
         m_st = 1; m_time = START_SECS; m_el = 0;
      end else if (m_st == 1 || m_st == 3) begin
         if (m_st == 1) begin
            if (bus.pause) m_st = 3;
            else begin
               m_el = m_el + 1;
               if (m_el == TICK_DIV) begin
                  m_el = 0; m_tick = 1'b1; sub = 1;
               end
            end
         end else if (!bus.pause) begin
            m_st = 1;
         end
`ifdef TIMER_PENALTY_EN
         if (bus.penalty) sub = sub + PENALTY_SECS;
`endif
         if (sub > 0) begin
            m_time = (m_time > sub) ? m_time - sub : 0;
            if (m_time == 0) m_st = 2;
         end
      end
      m_warn = (m_st == 1 || m_st == 3) && m_time >= 1 && m_time <= WARN_SECS;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic clear_inputs();
      bus.start = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0; bus.penalty = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b0;
      step(); step();
      rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         checks++;
         if (obs() !== expv()) begin
            failures++; $display("FAIL reset_idle: got %h want %h", obs(), expv());
         end
      end
      checks++;
      if (bus.cur_time !== 8'd3 || bus.s_time !== 2'b00 || bus.tick !== 1'b0 || bus.warn !== 1'b0) begin
         failures++;
         $display("FAIL reset_values: got t=%0d s=%b tick=%b warn=%b want 3 00 0 0",
                  bus.cur_time, bus.s_time, bus.tick, bus.warn);
      end
   endtask

   task automatic test_countdown();
      bus.start = 1'b1; step(); bus.start = 1'b0;
      checks++;
      if (bus.s_time !== 2'b01) begin
         failures++; $display("FAIL run_entry: got s=%b want 01", bus.s_time);
      end
      for (int c = 2; c <= 16; c++) begin
         step();
         checks++;
         if (obs() !== expv()) begin
            failures++; $display("FAIL countdown c=%0d: got %h want %h", c, obs(), expv());
         end
         if (c == 5 || c == 9 || c == 13) begin
            checks++;
            if (bus.tick !== 1'b1 || bus.cur_time !== 8'((13 - c) / 4)) begin
               failures++;
               $display("FAIL decrement c=%0d: got t=%0d tick=%b want t=%0d tick=1",
                        c, bus.cur_time, bus.tick, (13 - c) / 4);
            end
         end
         if (c == 9) begin
            checks++;
            if (bus.warn !== 1'b1) begin
               failures++; $display("FAIL warn_on: got %b want 1", bus.warn);
            end
         end
         if (c == 13 || c == 16) begin
            checks++;
            if (bus.s_time !== 2'b10 || bus.warn !== 1'b0 || bus.cur_time !== 8'd0) begin
               failures++;
               $display("FAIL expired c=%0d: got s=%b warn=%b t=%0d want 10 0 0",
                        c, bus.s_time, bus.warn, bus.cur_time);
            end
         end
      end
   endtask

   task automatic test_pause();
      int waited;
      bus.start = 1'b1; step(); bus.start = 1'b0;
      for (int c = 2; c <= 7; c++) step();
      bus.pause = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         checks++;
         if (bus.s_time !== 2'b11 || bus.cur_time !== 8'd2 || bus.tick !== 1'b0 || obs() !== expv()) begin
            failures++; $display("FAIL pause_hold i=%0d: got %h want s=11 t=2 tick=0 (%h)", i, obs(), expv());
         end
      end
      bus.pause = 1'b0;
      waited = 0;
      do begin
         step();
         waited++;
         checks++;
         if (obs() !== expv()) begin
            failures++; $display("FAIL pause_resume: got %h want %h", obs(), expv());
         end
      end while (bus.tick !== 1'b1 && waited < 10);
      checks++;
      if (waited != 3 || bus.cur_time !== 8'd1) begin
         failures++; $display("FAIL pause_remaining: got %0d cycles t=%0d want 3 cycles t=1", waited, bus.cur_time);
      end
   endtask

   task automatic test_start_stop();
      bus.start = 1'b1; step(); bus.start = 1'b0;
      for (int c = 2; c <= 6; c++) step();
      bus.start = 1'b1; bus.stop = 1'b1; step(); clear_inputs();
      checks++;
      if (bus.s_time !== 2'b00 || bus.cur_time !== 8'd2 || obs() !== expv()) begin
         failures++; $display("FAIL start_stop_together: got %h want s=00 t=2", obs());
      end
      step(); step(); step();
      checks++;
      if (bus.s_time !== 2'b00 || bus.cur_time !== 8'd2) begin
         failures++; $display("FAIL idle_hold: got %h want s=00 t=2", obs());
      end
      bus.start = 1'b1; step(); bus.start = 1'b0;
      checks++;
      if (bus.s_time !== 2'b01 || bus.cur_time !== 8'd3) begin
         failures++; $display("FAIL restart: got %h want s=01 t=3", obs());
      end
      bus.stop = 1'b1; step(); bus.stop = 1'b0;
   endtask

   task automatic test_penalty();
      bus.start = 1'b1; step(); bus.start = 1'b0;
`ifdef TIMER_PENALTY_EN
      bus.penalty = 1'b1; step(); bus.penalty = 1'b0;
      checks++;
      if (bus.cur_time !== 8'd1 || bus.warn !== 1'b1 || bus.s_time !== 2'b01) begin
         failures++; $display("FAIL penalty_first: got %h want t=1 warn=1 s=01", obs());
      end
      bus.penalty = 1'b1; step(); bus.penalty = 1'b0;
      checks++;
      if (bus.cur_time !== 8'd0 || bus.s_time !== 2'b10 || bus.warn !== 1'b0) begin
         failures++; $display("FAIL penalty_expire: got %h want t=0 s=10", obs());
      end
      bus.start = 1'b1; step(); bus.start = 1'b0;
      step(); step(); step();
      bus.penalty = 1'b1; step(); bus.penalty = 1'b0;
      checks++;
      if (bus.cur_time !== 8'd0 || bus.s_time !== 2'b10 || bus.tick !== 1'b1) begin
         failures++; $display("FAIL penalty_with_tick: got %h want t=0 s=10 tick=1", obs());
      end
      bus.start = 1'b1; step(); bus.start = 1'b0;
      bus.pause = 1'b1; step();
      bus.penalty = 1'b1; step(); bus.penalty = 1'b0;
      checks++;
      if (bus.cur_time !== 8'd1 || bus.s_time !== 2'b11 || bus.warn !== 1'b1) begin
         failures++; $display("FAIL penalty_in_pause: got %h want t=1 s=11 warn=1", obs());
      end
      bus.pause = 1'b0;
`else
      bus.penalty = 1'b1; step(); bus.penalty = 1'b0;
      checks++;
      if (bus.cur_time !== 8'd3 || bus.s_time !== 2'b01) begin
         failures++; $display("FAIL penalty_ignored: got %h want t=3 s=01", obs());
      end
`endif
      bus.stop = 1'b1; step(); bus.stop = 1'b0;
   endtask

   task automatic test_reset_midrun();
      int waited;
      bus.start = 1'b1; step(); bus.start = 1'b0;
      for (int c = 2; c <= 9; c++) step();
      checks++;
      if (bus.cur_time !== 8'd1) begin
         failures++; $display("FAIL pre_reset_time: got %0d want 1", bus.cur_time);
      end
      rst = 1'b0; step(); rst = 1'b1;
      checks++;
      if (bus.cur_time !== 8'd3 || bus.s_time !== 2'b00 || bus.tick !== 1'b0 || bus.warn !== 1'b0) begin
         failures++; $display("FAIL midrun_reset: got %h want t=3 s=00", obs());
      end
      bus.start = 1'b1; step(); bus.start = 1'b0;
      waited = 0;
      while (bus.s_time !== 2'b10 && waited < 40) begin
         step();
         waited++;
      end
      checks++;
      if (waited != 12) begin
         failures++; $display("FAIL full_run_length: got %0d cycles want 12", waited);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         rst         = ($urandom_range(0, 99) != 0);
         bus.start   = ($urandom_range(0, 19) == 0);
         bus.stop    = ($urandom_range(0, 29) == 0);
         bus.penalty = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 7) == 0) bus.pause = ~bus.pause;
         step();
         checks++;
         if (obs() !== expv()) begin
            failures++; $display("FAIL random i=%0d: got %h want %h", i, obs(), expv());
         end
      end
      clear_inputs();
      rst = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      clear_inputs();
      m_st = 0; m_time = START_SECS; m_el = 0; m_tick = 1'b0; m_warn = 1'b0;
      test_reset();
      test_countdown();
      test_pause();
      test_start_stop();
      test_penalty();
      test_reset_midrun();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
